// File: rtl/cond_unit_pkg.sv
// Shared condition codes and NZCV bit positions for the condition/flag stage.
package cond_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
endpackage

// File: rtl/cond_unit_check.sv
// Combinational condition evaluation: 4-bit condition field against stored NZCV.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      // 4'b1111 has no distinct meaning here and executes unconditionally
      default: cond_ex = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// NZCV flags register with per-pair write enables, condition gating of the write
// enables, and the stored carry fed back to the ALU.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       Carry,
  output logic [3:0] Flags
);
  logic [3:0] nzcv;

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (nzcv),
    .cond_ex (CondEx)
  );

  // Condition is judged on the flags held before this edge, so a conditional
  // flag-setting instruction sees pre-update values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      nzcv <= RESET_FLAGS;
    end else if (CondEx && !Stall) begin
      if (FlagW[FLAGW_NZ]) nzcv[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[FLAGW_CV]) nzcv[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;
  assign Carry    = nzcv[FLAG_C];
  assign Flags    = nzcv;
endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: reset, flag capture/hold, stall freeze, gating and full condition sweep.
module tb_cond_unit;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, Stall;
  logic       PCSrc, RegWrite, MemWrite, CondEx, Carry;
  logic [3:0] Flags;

  int checks = 0;
  int fails  = 0;

  cond_unit #(.RESET_FLAGS(4'b0000)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .Stall    (Stall),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Carry    (Carry),
    .Flags    (Flags)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Independent reference: conditions come in pairs, odd code inverts the even one.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  task automatic load_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    RESET = 1'b1; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;
    tick();
    chk("reset_flags", Flags, 4'b0000);
    chk("reset_carry", {3'b0, Carry}, 4'd0);
    Cond = 4'b0000; #1;
    chk("reset_eq", {3'b0, CondEx}, 4'd0);
    Cond = 4'b0001; #1;
    chk("reset_ne", {3'b0, CondEx}, 4'd1);

    RESET = 1'b0;
    load_flags(4'b0110);
    chk("cmp_flags", Flags, 4'b0110);
    Cond = 4'b0000; PCS = 1'b1; #1;
    chk("eq_pcsrc", {3'b0, PCSrc}, 4'd1);
    Stall = 1'b1; #1;
    chk("pcsrc_not_stalled", {3'b0, PCSrc}, 4'd1);
    Stall = 1'b0; PCS = 1'b0;
    Cond = 4'b1000; #1;
    chk("hi_false", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1001; #1;
    chk("ls_true", {3'b0, CondEx}, 4'd1);

    load_flags(4'b0010);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1001;
    tick();
    FlagW = 2'b00;
    chk("ands_keep_cv", Flags, 4'b1010);

    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1'b1; #1;
    chk("eq_fail_condex", {3'b0, CondEx}, 4'd0);
    chk("eq_fail_regwrite", {3'b0, RegWrite}, 4'd0);
    tick();
    chk("eq_fail_flags_hold", Flags, 4'b0000);
    RegW = 1'b0;

    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1001; Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_freeze", Flags, 4'b0000);
    end
    Stall = 1'b0;
    tick();
    FlagW = 2'b00;
    chk("stall_release", Flags, 4'b1001);
    Cond = 4'b1010; #1; chk("ge", {3'b0, CondEx}, 4'd1);
    Cond = 4'b1011; #1; chk("lt", {3'b0, CondEx}, 4'd0);
    Cond = 4'b1100; #1; chk("gt", {3'b0, CondEx}, 4'd1);
    Cond = 4'b1101; #1; chk("le", {3'b0, CondEx}, 4'd0);
    chk("carry_tap", {3'b0, Carry}, 4'd0);

    Cond = 4'b1110; RegW = 1'b1; NoWrite = 1'b1; MemW = 1'b1; #1;
    chk("nowrite_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("memwrite_al", {3'b0, MemWrite}, 4'd1);
    NoWrite = 1'b0; #1;
    chk("regwrite_al", {3'b0, RegWrite}, 4'd1);
    RegW = 1'b0; MemW = 1'b0;

    load_flags(4'b0110);
    RESET = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    chk("reset_overrides_write", Flags, 4'b0000);
    RESET = 1'b0; FlagW = 2'b00;

    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      chk("sweep_flags", Flags, 4'(f));
      chk("sweep_carry", {3'b0, Carry}, {3'b0, 1'(f >> 1)});
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); #1;
        chk($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, CondEx}, {3'b0, ref_cond(4'(c), 4'(f))});
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
